// File: rtl/pulse_framed_deserialiser_pkg.sv
// Shared defaults and receive-FSM encoding for the pulse-framed deserialiser.
package pulse_framed_deserialiser_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO; a push into a full buffer is accepted only when a pop frees a slot that cycle.
module sync_word_fifo
  import pulse_framed_deserialiser_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pulse_framed_deserialiser.sv
// Deserialises MSB-first frames marked by a start pulse into a word FIFO,
// with sticky overflow/abort flags and an accepted-word counter.
module pulse_framed_deserialiser
  import pulse_framed_deserialiser_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              frame_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clear_flags,
  output logic              overflow,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int SHR_W = DATA_W - 1;

  rx_state_e         state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [SHR_W-1:0]  shreg_r, shreg_nxt_s;
  logic              push_s;
  logic              err_set_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              drop_s;
  logic              accept_s;
  logic [DATA_W-1:0] word_s;

  assign word_s    = {shreg_r, serial_in};
  assign out_valid = !empty_s;
  assign pop_s     = out_valid && out_ready;
  assign drop_s    = push_s && full_s && !pop_s;
  assign accept_s  = push_s && !drop_s;

  // Receive state, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      shreg_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      shreg_r <= shreg_nxt_s;
    end
  end

  // Next-state: a start pulse always restarts capture on the current bit, even mid-frame.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shreg_nxt_s = shreg_r;
    push_s      = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_valid) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = CNT_W'(1);
          shreg_nxt_s = SHR_W'(serial_in);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (frame_valid) begin
          err_set_s   = 1'b1;
          cnt_nxt_s   = CNT_W'(1);
          shreg_nxt_s = SHR_W'(serial_in);
        end else if (cnt_r == CNT_W'(DATA_W - 1)) begin
          push_s      = 1'b1;
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
          shreg_nxt_s = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          shreg_nxt_s = {shreg_r[SHR_W-2:0], serial_in};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
        shreg_nxt_s = '0;
      end
    endcase
  end

  // Sticky flags (set beats clear) and accepted-word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
      if (err_set_s) begin
        frame_err <= 1'b1;
      end else if (clear_flags) begin
        frame_err <= 1'b0;
      end else begin
        frame_err <= frame_err;
      end
      if (accept_s) begin
        frame_count <= frame_count + 16'd1;
      end else begin
        frame_count <= frame_count;
      end
    end
  end

  sync_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (word_s),
    .pop       (pop_s),
    .pop_data  (out_data),
    .full      (full_s),
    .empty     (empty_s)
  );

endmodule

// File: tb/tb_pulse_framed_deserialiser.sv
// Directed bench for pulse_framed_deserialiser: single, back-to-back, abort, overflow,
// full-with-pop and mid-frame reset scenarios with hand-computed expectations.
module tb_pulse_framed_deserialiser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_in;
  logic        frame_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clear_flags;
  logic        overflow;
  logic        frame_err;
  logic [15:0] frame_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pulse_framed_deserialiser #(
    .DATA_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .frame_valid (frame_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_flags (clear_flags),
    .overflow    (overflow),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the first n bits of w, MSB first, with the start pulse on the first bit.
  task automatic drive_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      frame_valid = (i == 0);
      serial_in   = w[15-i];
      step();
    end
    frame_valid = 1'b0;
    serial_in   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; serial_in = 1'b0; frame_valid = 1'b0;
    out_ready = 1'b0; clear_flags = 1'b0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    rst_n = 1'b1;

    // Idle serial activity without a start pulse is ignored
    serial_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    serial_in = 1'b0;
    chk("idle_ignored", {31'd0, out_valid}, 32'd0);

    // Single frame, latency check one bit before the end
    out_ready = 1'b1;
    drive_bits(16'hA5C3, 15);
    chk("single_not_early", {31'd0, out_valid}, 32'd0);
    serial_in = 1'b1;
    step();
    serial_in = 1'b0;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {16'd0, out_data}, 32'hA5C3);
    chk("single_count", {16'd0, frame_count}, 32'd1);
    step();
    chk("single_popped", {31'd0, out_valid}, 32'd0);

    // Back-to-back frames
    out_ready = 1'b0;
    drive_bits(16'h0001, 16);
    drive_bits(16'hFFFF, 16);
    chk("b2b_first", {16'd0, out_data}, 32'h0001);
    chk("b2b_count", {16'd0, frame_count}, 32'd3);
    chk("b2b_no_err", {31'd0, frame_err}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("b2b_second", {16'd0, out_data}, 32'hFFFF);
    step();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Abort at bit 7 by a new start pulse
    out_ready = 1'b0;
    drive_bits(16'h5555, 7);
    drive_bits(16'h1234, 16);
    chk("abort_err", {31'd0, frame_err}, 32'd1);
    chk("abort_data", {16'd0, out_data}, 32'h1234);
    chk("abort_count", {16'd0, frame_count}, 32'd4);
    out_ready = 1'b1;
    step();
    chk("abort_one_word", {31'd0, out_valid}, 32'd0);

    // Clear, then abort on the last-bit cycle
    out_ready = 1'b0;
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("clear_err", {31'd0, frame_err}, 32'd0);
    drive_bits(16'hFFFF, 15);
    drive_bits(16'h00AA, 16);
    chk("lastbit_abort_err", {31'd0, frame_err}, 32'd1);
    chk("lastbit_abort_data", {16'd0, out_data}, 32'h00AA);
    chk("lastbit_abort_count", {16'd0, frame_count}, 32'd5);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("lastbit_abort_one", {31'd0, out_valid}, 32'd0);

    // Overflow: five frames into a four-deep buffer
    for (int k = 0; k < 4; k++) drive_bits(16'h0010 + 16'(k), 16);
    chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
    drive_bits(16'h0014, 16);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {16'd0, frame_count}, 32'd9);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", {16'd0, out_data}, 32'h0010 + 32'(k));
      step();
    end
    chk("ovf_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full buffer with a pop on the push cycle
    for (int k = 0; k < 4; k++) drive_bits(16'h0020 + 16'(k), 16);
    drive_bits(16'h0024, 15);
    out_ready = 1'b1;
    serial_in = 1'b0;
    step();
    chk("fullpop_no_ovf", {31'd0, overflow}, 32'd0);
    chk("fullpop_count", {16'd0, frame_count}, 32'd14);
    for (int k = 1; k < 5; k++) begin
      chk("fullpop_order", {16'd0, out_data}, 32'h0020 + 32'(k));
      step();
    end
    chk("fullpop_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Overflow set coinciding with clear_flags: set wins
    for (int k = 0; k < 4; k++) drive_bits(16'h0030 + 16'(k), 16);
    drive_bits(16'h0034, 15);
    clear_flags = 1'b1; serial_in = 1'b0;
    step();
    clear_flags = 1'b0;
    chk("setwins_ovf", {31'd0, overflow}, 32'd1);
    chk("setwins_count", {16'd0, frame_count}, 32'd18);

    // Reset at bit 8 of a frame, then a clean frame
    drive_bits(16'hDEAD, 8);
    rst_n = 1'b0; serial_in = 1'b1;
    step();
    rst_n = 1'b1; serial_in = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_flags", {30'd0, overflow, frame_err}, 32'd0);
    chk("midrst_count", {16'd0, frame_count}, 32'd0);
    for (int i = 0; i < 8; i++) step();
    chk("midrst_partial_gone", {31'd0, out_valid}, 32'd0);
    drive_bits(16'hBEEF, 16);
    chk("beef_data", {16'd0, out_data}, 32'hBEEF);
    chk("beef_count", {16'd0, frame_count}, 32'd1);
    chk("beef_flags", {30'd0, overflow, frame_err}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("beef_only", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_framed_deserialiser.md
PULSE_FRAMED_DESERIALISER -- requirements
Module: pulse_framed_deserialiser

Interface
REQ-001 Parameter DATA_W, default 16, word width; frame length is DATA_W bits.
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer depth; power of two, at least 2.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 serial_in  in  1  serial data, MSB first, one bit per clk.
REQ-006 frame_valid  in  1  single-cycle pulse coincident with the MSB of a frame.
REQ-007 out_data  out  DATA_W  head-of-buffer word.
REQ-008 out_valid  out  1  buffer non-empty; out_data is valid.
REQ-009 out_ready  in  1  consumer accepts; a pop occurs when out_valid && out_ready.
REQ-010 clear_flags  in  1  clears overflow and frame_err.
REQ-011 overflow  out  1  sticky; a completed word was dropped because the buffer was full.
REQ-012 frame_err  out  1  sticky; a frame was aborted by an early frame_valid.
REQ-013 frame_count  out  16  number of words written to the buffer, wraps modulo 2^16.

Function
REQ-014 The receive FSM SHALL have two states: IDLE and SHIFT.
REQ-015 IDLE -> SHIFT on frame_valid=1: capture serial_in as bit DATA_W-1 and load bit counter = 1.
REQ-016 In SHIFT, each cycle SHALL shift serial_in into the LSB and increment the counter.
REQ-017 When the counter reaches DATA_W-1 and that bit is sampled, the full word SHALL be pushed into the buffer and the FSM SHALL return to IDLE.
REQ-018 Latency: if frame_valid is at cycle N, the word is pushed at the end of cycle N+DATA_W-1, and out_valid rises in cycle N+DATA_W when the buffer was empty.
REQ-019 Back-to-back frames SHALL be accepted: frame_valid at cycle N+DATA_W (immediately after the last bit) starts the next frame with no loss.
REQ-020 frame_valid while in SHIFT, including on the last-bit cycle, SHALL discard the partial word, set frame_err, and restart capture with the current bit as the new MSB.
REQ-021 frame_valid has no effect on serial_in sampling in IDLE other than starting a frame; serial_in in IDLE without frame_valid SHALL be ignored.
REQ-022 Push to a full buffer SHALL drop the word, set overflow, and leave frame_count unchanged, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-023 Simultaneous push and pop on an empty buffer SHALL NOT bypass: out_valid rises the next cycle.
REQ-024 Buffer order is strict FIFO; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 frame_count SHALL increment by 1 per accepted push, wrapping from 0xFFFF to 0x0000.
REQ-026 If clear_flags coincides with a new flag-setting event, the set SHALL win.

Reset
REQ-027 While rst_n=0 at a clock edge: FSM=IDLE, counter=0, shift register=0, buffer empty, out_valid=0, out_data=0, overflow=0, frame_err=0, frame_count=0.
REQ-028 A reset mid-frame SHALL discard the partial word; the first frame_valid after reset release starts a clean frame.

Structure
REQ-029 A shared package SHALL hold DATA_W and FIFO_DEPTH defaults and the FSM state encoding (IDLE=0, SHIFT=1).
REQ-030 The output buffer SHALL be a sub-module, sync_word_fifo (push/pop/full/empty, same clock and reset); the FSM, shift register, flags and counter stay in the top level.

Verification
REQ-031 Single frame: frame_valid at cycle 0 with bits of 0xA5C3 MSB first, out_ready=1 -> out_valid=1 at cycle 16 with out_data=0xA5C3, frame_count=1.
REQ-032 Back-to-back: words 0x0001 and 0xFFFF with frame_valid at cycles 0 and 16 -> both popped in order, no frame_err.
REQ-033 Abort: frame_valid at cycle 0, again at cycle 7, then 16 bits of 0x1234 -> frame_err=1, only 0x1234 delivered, frame_count=1.
REQ-034 Overflow: out_ready=0, 5 frames 0x0010..0x0014 -> buffer holds 0x0010..0x0013, overflow=1, frame_count=4; clear_flags -> overflow=0.
REQ-035 Full with simultaneous pop: buffer full, out_ready=1 on the push cycle -> no overflow, the 5th word retained.
REQ-036 Reset mid-frame: rst_n=0 at bit 8 of a frame, then a full 0xBEEF frame -> only 0xBEEF output, all flags 0.
